// File: rtl/router_pkt_tx_if.sv
// router_pkt_tx_if: host-side load/start controls and router-side byte stream of the packet transmitter
interface router_pkt_tx_if;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       start;
  logic [1:0] dest_addr;
  logic       abort;
  logic       busy;
  logic [7:0] data_out;
  logic       pkt_valid;
  logic       tx_idle;
  logic       done;
  logic       err;
  logic       buf_full;
  logic [5:0] buf_count;
  modport master (
    output wr_en, wr_data, start, dest_addr, abort, busy,
    input  data_out, pkt_valid, tx_idle, done, err, buf_full, buf_count
  );
  modport slave (
    input  wr_en, wr_data, start, dest_addr, abort, busy,
    output data_out, pkt_valid, tx_idle, done, err, buf_full, buf_count
  );
endinterface

// File: rtl/router_pkt_tx.sv
// router_pkt_tx: buffers a payload, then sends header, payload and XOR parity to the router under busy back-pressure
module router_pkt_tx #(
  parameter int MAX_LEN = 63
) (
  input logic            clk,
  input logic            rst,
  router_pkt_tx_if.slave bus
);
  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, PARITY} state_t;
  state_t     state_q, state_d;
  logic [7:0] mem_q [64];
  logic [5:0] count_q, count_d, rd_q, rd_d, len_q, len_d;
  logic [7:0] data_q, data_d, par_q, par_d, nxt;
  logic       pv_q, pv_d, done_q, done_d, err_q, err_d, wr_ok;
  assign bus.data_out  = data_q;
  assign bus.pkt_valid = pv_q;
  assign bus.tx_idle   = state_q == IDLE;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.buf_count = count_q;
  assign bus.buf_full  = count_q == 6'(MAX_LEN);
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rd_d    = rd_q;
    len_d   = len_q;
    data_d  = data_q;
    par_d   = par_q;
    pv_d    = pv_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    wr_ok   = state_q == IDLE && bus.wr_en && !bus.start && !bus.abort && count_q < 6'(MAX_LEN);
    nxt     = mem_q[rd_q + 6'd1];
    if (bus.abort) begin
      state_d = IDLE;
      count_d = '0;
      data_d  = '0;
      pv_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (count_q == '0 || bus.dest_addr == 2'd3) begin
              err_d = 1'b1;
            end else begin
              len_d   = count_q;
              data_d  = {count_q, bus.dest_addr};
              par_d   = {count_q, bus.dest_addr};
              pv_d    = 1'b1;
              state_d = HEADER;
            end
          end else if (wr_ok) begin
            count_d = count_q + 6'd1;
          end
        end
        HEADER: begin
          if (!bus.busy) begin
            rd_d    = '0;
            data_d  = mem_q[0];
            par_d   = par_q ^ mem_q[0];
            state_d = PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (!bus.busy) begin
            if (7'(rd_q) + 7'd1 < 7'(len_q)) begin
              rd_d   = rd_q + 6'd1;
              data_d = nxt;
              par_d  = par_q ^ nxt;
            end else begin
              data_d  = par_q;
              pv_d    = 1'b0;
              state_d = PARITY;
            end
          end
        end
        PARITY: begin
          if (!bus.busy) begin
            state_d = IDLE;
            data_d  = '0;
            count_d = '0;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[count_q] <= bus.wr_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      rd_q    <= '0;
      len_q   <= '0;
      data_q  <= '0;
      par_q   <= '0;
      pv_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rd_q    <= rd_d;
      len_q   <= len_d;
      data_q  <= data_d;
      par_q   <= par_d;
      pv_q    <= pv_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
endmodule
